// File: rtl/fc_pkg.sv
// Shared constants, packed-word type and FSM encoding for the full_connect output packer.
package fc_pkg;

  localparam int FC_DATA_W = 32;
  localparam int FC_PACK   = 8;
  localparam int FC_WORD_W = FC_DATA_W * FC_PACK;

  typedef logic [FC_WORD_W-1:0] fc_word_t;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_ACC   = 2'd1,
    FC_DRAIN = 2'd2,
    FC_DONE  = 2'd3
  } fc_state_t;

endpackage

// File: rtl/fc_word_fifo.sv
// First-word-fall-through FIFO holding {addr,data} packed words.
// A push into a full FIFO is accepted when the head pops in the same cycle.
module fc_word_fifo #(
  parameter int W     = 265,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_eff;
  logic          push_eff;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  // Head is shown only while an entry exists, so an empty FIFO presents zeros.
  assign head = empty ? '0 : mem_reg[rd_ptr_reg];

  // Storage write; when full with a pop, the freed head slot becomes the new tail.
  always_ff @(posedge clk) begin
    if (push_eff && !clr) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
    end
  end

endmodule

// File: rtl/fc_fout_packer.sv
// Applies optional ReLU to serial float outputs, packs PACK of them per word
// and streams the words through a small FIFO to the feature-map write path.
module fc_fout_packer import fc_pkg::*; #(
  parameter int DATA_W     = FC_DATA_W,
  parameter int PACK       = FC_PACK,
  parameter int IDX_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            relu_en,
  input  logic [IDX_W:0]                  fout_num,
  input  logic [DATA_W-1:0]               fc_fout,
  input  logic                            fc_fout_vld,
  input  logic [IDX_W-1:0]                fc_fout_idx,
  output logic [DATA_W*PACK-1:0]          wr_data,
  output logic [IDX_W-$clog2(PACK)-1:0]   wr_addr,
  output logic                            wr_vld,
  input  logic                            wr_rdy,
  output logic                            busy,
  output logic                            done,
  output logic                            seq_err,
  output logic                            ovf_err
);

  localparam int LW     = $clog2(PACK);
  localparam int AW     = IDX_W - LW;
  localparam int WORD_W = DATA_W * PACK;
  localparam int ENT_W  = AW + WORD_W;

  fc_state_t         state_reg, state_next;
  logic [IDX_W:0]    fout_num_reg;
  logic [IDX_W:0]    cnt_reg;
  logic [IDX_W:0]    cnt_inc;
  logic [IDX_W-1:0]  exp_idx_reg;
  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] pack_word;
  logic              seq_err_reg;
  logic              ovf_err_reg;

  logic              accept;
  logic              is_last;
  logic              push;
  logic              pop;
  logic              drop;
  logic [LW-1:0]     lane;
  logic [DATA_W-1:0] relu_val;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept   = (state_reg == FC_ACC) && fc_fout_vld && !start;
  assign lane     = fc_fout_idx[LW-1:0];
  assign relu_val = (relu_en && fc_fout[DATA_W-1]) ? '0 : fc_fout;
  assign cnt_inc  = cnt_reg + (IDX_W+1)'(1);
  assign is_last  = (cnt_inc == fout_num_reg);
  assign push     = accept && ((lane == LW'(PACK-1)) || is_last);
  assign pop      = wr_vld && wr_rdy;
  assign drop     = push && fifo_full && !pop;

  // Word being assembled this cycle: the incoming value overlays its lane.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign pack_word[gi*DATA_W +: DATA_W] =
      (accept && (lane == LW'(gi))) ? relu_val : pack_reg[gi*DATA_W +: DATA_W];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= FC_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; start restarts the layer from any state.
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = (fout_num == '0) ? FC_DONE : FC_ACC;
    end else begin
      case (state_reg)
        FC_ACC:   if (accept && is_last) state_next = FC_DRAIN;
        FC_DRAIN: if (fifo_empty)        state_next = FC_DONE;
        default:  state_next = state_reg;
      endcase
    end
  end

  // Layer counters, pack register and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fout_num_reg <= '0;
      cnt_reg      <= '0;
      exp_idx_reg  <= '0;
      pack_reg     <= '0;
      seq_err_reg  <= 1'b0;
      ovf_err_reg  <= 1'b0;
    end else if (start) begin
      fout_num_reg <= fout_num;
      cnt_reg      <= '0;
      exp_idx_reg  <= '0;
      pack_reg     <= '0;
      seq_err_reg  <= 1'b0;
      ovf_err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg     <= cnt_inc;
        exp_idx_reg <= exp_idx_reg + IDX_W'(1);
        pack_reg    <= push ? '0 : pack_word;
        if (fc_fout_idx != exp_idx_reg) seq_err_reg <= 1'b1;
      end
      if (drop) ovf_err_reg <= 1'b1;
    end
  end

  fc_word_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .push      (push),
    .push_data ({fc_fout_idx[IDX_W-1:LW], pack_word}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_vld  = !fifo_empty;
  assign wr_addr = fifo_head[ENT_W-1:WORD_W];
  assign wr_data = fifo_head[WORD_W-1:0];
  assign busy    = (state_reg == FC_ACC) || (state_reg == FC_DRAIN);
  assign done    = (state_reg == FC_DONE);
  assign seq_err = seq_err_reg;
  assign ovf_err = ovf_err_reg;

endmodule

// File: tb/tb_fc_fout_packer.sv
// Scoreboard bench for fc_fout_packer: expected words are queued as outputs
// are driven and compared as the write port hands them over.
`timescale 1ns/1ps
module tb_fc_fout_packer;
  import fc_pkg::*;

  typedef struct packed {
    logic [8:0] addr;
    fc_word_t   data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         relu_en;
  logic [12:0]  fout_num;
  logic [31:0]  fc_fout;
  logic         fc_fout_vld;
  logic [11:0]  fc_fout_idx;
  logic [255:0] wr_data;
  logic [8:0]   wr_addr;
  logic         wr_vld;
  logic         wr_rdy;
  logic         busy;
  logic         done;
  logic         seq_err;
  logic         ovf_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_words = 0;
  int w0;

  exp_t        sb_q[$];
  logic [31:0] stim_val[64];
  logic [11:0] stim_idx[64];

  logic         hold_pending = 1'b0;
  logic [255:0] hold_data;
  logic [8:0]   hold_addr;

  always #5 clk = ~clk;

  fc_fout_packer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .relu_en     (relu_en),
    .fout_num    (fout_num),
    .fc_fout     (fc_fout),
    .fc_fout_vld (fc_fout_vld),
    .fc_fout_idx (fc_fout_idx),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_vld      (wr_vld),
    .wr_rdy      (wr_rdy),
    .busy        (busy),
    .done        (done),
    .seq_err     (seq_err),
    .ovf_err     (ovf_err)
  );

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write-port monitor: stability while stalled, scoreboard compare on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending && wr_vld) begin
          check_val("stall_data", wr_data, hold_data);
          check_val("stall_addr", {247'd0, wr_addr}, {247'd0, hold_addr});
        end
        hold_pending = 1'b0;
        if (wr_vld && wr_rdy) begin
          n_words++;
          $display("[TB] word addr=%0d data=%h", wr_addr, wr_data);
          if (sb_q.size() == 0) begin
            check_val("unexpected_word", 256'd1, 256'd0);
          end else begin
            e = sb_q.pop_front();
            check_val("word_addr", {247'd0, wr_addr}, {247'd0, e.addr});
            check_val("word_data", wr_data, e.data);
          end
        end else if (wr_vld) begin
          hold_pending = 1'b1;
          hold_data    = wr_data;
          hold_addr    = wr_addr;
        end
      end
    end
  end

  // Start a layer of num outputs, feed the first n_feed stimulus entries, and
  // queue the expected words (only the first 'limit' words survive).
  task automatic run_layer(input int num, input bit relu, input int limit,
                           input int err_at, input int n_feed);
    logic [31:0] ml [8];
    logic [2:0]  ln;
    int          pushed = 0;
    exp_t        e;
    for (int k = 0; k < 8; k++) ml[k] = 32'h0;
    @(posedge clk); #1;
    relu_en  = relu;
    fout_num = num[12:0];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n_feed; i++) begin
      fc_fout_vld = 1'b1;
      fc_fout_idx = stim_idx[i];
      fc_fout     = stim_val[i];
      ln          = stim_idx[i][2:0];
      ml[ln]      = (relu && stim_val[i][31]) ? 32'h0 : stim_val[i];
      if (ln == 3'd7 || i == num - 1) begin
        if (pushed < limit) begin
          e.addr = stim_idx[i][11:3];
          for (int k = 0; k < 8; k++) e.data[32*k +: 32] = ml[k];
          sb_q.push_back(e);
        end
        pushed++;
        for (int k = 0; k < 8; k++) ml[k] = 32'h0;
      end
      @(posedge clk); #1;
      check_val($sformatf("seq_err_%0d", i), {255'd0, seq_err},
                {255'd0, (err_at >= 0 && i >= err_at)});
    end
    fc_fout_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check_val(tag, {255'd0, done}, 256'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; fout_num = '0;
    fc_fout = '0; fc_fout_vld = 1'b0; fc_fout_idx = '0; wr_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_wr_vld",  {255'd0, wr_vld},  256'd0);
    check_val("rst_wr_data", wr_data,           256'd0);
    check_val("rst_wr_addr", {247'd0, wr_addr}, 256'd0);
    check_val("rst_busy",    {255'd0, busy},    256'd0);
    check_val("rst_done",    {255'd0, done},    256'd0);
    check_val("rst_seq_err", {255'd0, seq_err}, 256'd0);
    check_val("rst_ovf_err", {255'd0, ovf_err}, 256'd0);
    rst = 1'b0;

    // 1: sixteen consecutive outputs, two full words
    for (int i = 0; i < 16; i++) begin stim_idx[i] = 12'(i); stim_val[i] = 32'h3F800000 + 32'(i); end
    w0 = n_words;
    run_layer(16, 1'b0, 99, -1, 16);
    check_val("t1_busy", {255'd0, busy}, 256'd1);
    wait_done("t1_done");
    check_val("t1_words",   256'(n_words - w0), 256'd2);
    check_val("t1_sb",      256'(sb_q.size()),  256'd0);
    check_val("t1_seq_err", {255'd0, seq_err},  256'd0);
    check_val("t1_ovf_err", {255'd0, ovf_err},  256'd0);

    // 2: ReLU, including -0 and a negative NaN
    for (int i = 0; i < 8; i++) begin
      stim_idx[i] = 12'(i);
      stim_val[i] = (i % 2 == 0) ? 32'hBF800000 : 32'h40000000;
    end
    stim_val[4] = 32'h80000000;
    stim_val[6] = 32'hFFC00000;
    w0 = n_words;
    run_layer(8, 1'b1, 99, -1, 8);
    wait_done("t2_done");
    check_val("t2_words", 256'(n_words - w0), 256'd1);
    check_val("t2_sb",    256'(sb_q.size()),  256'd0);

    // 3: partial last word, negative values passed bit-exact with ReLU off
    for (int i = 0; i < 13; i++) begin stim_idx[i] = 12'(i); stim_val[i] = 32'hC0000000 + 32'(i); end
    w0 = n_words;
    run_layer(13, 1'b0, 99, -1, 13);
    check_val("t3_drain", 256'(dut.state_reg), 256'(FC_DRAIN));
    check_val("t3_busy",  {255'd0, busy}, 256'd1);
    wait_done("t3_done");
    check_val("t3_words", 256'(n_words - w0), 256'd2);
    check_val("t3_sb",    256'(sb_q.size()),  256'd0);

    // 4: stalled write path, words 5 and 6 dropped
    for (int i = 0; i < 48; i++) begin stim_idx[i] = 12'(i); stim_val[i] = 32'h10000000 + 32'(i); end
    wr_rdy = 1'b0;
    w0 = n_words;
    run_layer(48, 1'b0, 4, -1, 48);
    repeat (3) begin @(posedge clk); #1; end
    check_val("t4_ovf_err", {255'd0, ovf_err}, 256'd1);
    check_val("t4_wr_vld",  {255'd0, wr_vld},  256'd1);
    check_val("t4_busy",    {255'd0, busy},    256'd1);
    wr_rdy = 1'b1;
    wait_done("t4_done");
    check_val("t4_words", 256'(n_words - w0), 256'd4);
    check_val("t4_sb",    256'(sb_q.size()),  256'd0);

    // 5: index skip 0,1,3
    stim_idx[0] = 12'd0; stim_val[0] = 32'hA0000000;
    stim_idx[1] = 12'd1; stim_val[1] = 32'hA0000001;
    stim_idx[2] = 12'd3; stim_val[2] = 32'hA0000003;
    run_layer(3, 1'b0, 99, 2, 3);
    wait_done("t5_done");
    check_val("t5_sb", 256'(sb_q.size()), 256'd0);
    @(posedge clk); #1;
    fout_num = 13'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("t5_seq_clr",  {255'd0, seq_err}, 256'd0);
    check_val("t5_zero_done", {255'd0, done},   256'd1);
    check_val("t5_zero_busy", {255'd0, busy},   256'd0);

    // 6: asynchronous reset mid-layer with two words queued
    for (int i = 0; i < 32; i++) begin stim_idx[i] = 12'(i); stim_val[i] = 32'h55000000 + 32'(i); end
    wr_rdy = 1'b0;
    w0 = n_words;
    run_layer(32, 1'b0, 99, -1, 16);
    check_val("t6_pre_vld", {255'd0, wr_vld}, 256'd1);
    #2 rst = 1'b1;
    #1;
    check_val("t6_rst_vld",   {255'd0, wr_vld},            256'd0);
    check_val("t6_rst_busy",  {255'd0, busy},              256'd0);
    check_val("t6_rst_empty", {255'd0, dut.u_fifo.empty},  256'd1);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; wr_rdy = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check_val("t6_idle_vld",   {255'd0, wr_vld},   256'd0);
    check_val("t6_idle_done",  {255'd0, done},     256'd0);
    check_val("t6_idle_words", 256'(n_words - w0), 256'd0);

    // 7: restart after reset
    for (int i = 0; i < 8; i++) begin stim_idx[i] = 12'(i); stim_val[i] = 32'h7F000000 + 32'(i); end
    w0 = n_words;
    run_layer(8, 1'b0, 99, -1, 8);
    wait_done("t7_done");
    check_val("t7_words", 256'(n_words - w0), 256'd1);
    check_val("t7_sb",    256'(sb_q.size()),  256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
